// File: rtl/sram_arbiter.sv
// Two-client round-robin arbiter in front of a single SRAM controller port.
// Read data is routed back to its requester through an in-order tag FIFO.
module sram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              c0_req,
  input  logic              c0_rd,
  input  logic [1:0]        c0_be,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wr_data,
  output logic              c0_ready,
  output logic              c0_rd_data_vld,

  input  logic              c1_req,
  input  logic              c1_rd,
  input  logic [1:0]        c1_be,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wr_data,
  output logic              c1_ready,
  output logic              c1_rd_data_vld,

  output logic [DATA_W-1:0] rd_data,

  output logic              sram_req,
  output logic              sram_rd,
  output logic [1:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic              sram_ready,
  input  logic [DATA_W-1:0] sram_rd_data,
  input  logic              sram_rd_data_vld,

  output logic              rd_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic   grant;
  logic   last_served;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] tag_cnt;
  logic             tag_mem [TAG_DEPTH];

  logic req_g;
  logic rd_g;
  logic tag_full;
  logic tag_empty;
  logic stall;
  logic xfer;
  logic push;
  logic pop;
  logic tag_head;

  // Granted client's fields are steered straight through to the controller.
  always_comb begin
    req_g        = grant ? c1_req     : c0_req;
    rd_g         = grant ? c1_rd      : c0_rd;
    sram_rd      = rd_g;
    sram_be      = grant ? c1_be      : c0_be;
    sram_addr    = grant ? c1_addr    : c0_addr;
    sram_wr_data = grant ? c1_wr_data : c0_wr_data;
  end

  // A full FIFO stalls reads even when a pop lands in the same cycle; writes never stall.
  always_comb begin
    tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    tag_empty = (tag_cnt == '0);
    stall     = rd_g & tag_full;
    sram_req  = (state == BUSY) & ~rst & req_g & ~stall;
    xfer      = sram_req & sram_ready;
    c0_ready  = xfer & ~grant;
    c1_ready  = xfer &  grant;
    push      = xfer & rd_g;
  end

  always_comb begin
    tag_head       = tag_mem[rd_ptr];
    pop            = sram_rd_data_vld & ~tag_empty & ~rst;
    c0_rd_data_vld = pop & ~tag_head;
    c1_rd_data_vld = pop &  tag_head;
    rd_data        = sram_rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (c0_req | c1_req) begin
            state <= BUSY;
            grant <= (c0_req & c1_req) ? ~last_served : c1_req;
          end
        end
        BUSY: begin
          if (xfer) begin
            last_served <= grant;
            state       <= IDLE;
          end else if (!req_g) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_cnt   <= '0;
      rd_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (sram_rd_data_vld && tag_empty) rd_orphan <= 1'b1;
    end
  end

  // NOTE: the tag storage is deliberately not reset; entries are only read
  // between pointers that reset does clear, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

endmodule
